// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame check for the PS/2 receiver
package ps2_pkg;
  localparam int PS2_FRAME_BITS  = 11;
  localparam int START           = 0;
  localparam int PAR             = 9;
  localparam int STOP            = 10;
  localparam int PS2_FIFO_DEPTH  = 8;
  localparam int PS2_TIMEOUT_CYC = 50000;

  // Start low, stop high, odd parity across the data byte and parity bit.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[START] == 1'b0) && (f[STOP] == 1'b1) && ((^f[PAR:START+1]) == 1'b1);
  endfunction
endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - show-ahead synchronous FIFO, write accepted when full if a pop coincides
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_rd, do_wr;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rp[AW-1:0]];
endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver feeding a byte FIFO
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = PS2_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]                s;
  logic [1:0]                d;
  logic [3:0]                cnt;
  logic [PS2_FRAME_BITS-2:0] sr;
  logic [WDW-1:0]            wd;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic                      fall, last, good, full, empty, pop;

  assign fall  = s[2] & ~s[1];
  // Frame as it stands once the bit arriving on this edge is included.
  assign frame = {d[1], sr};
  assign last  = fall && (cnt == 4'(PS2_FRAME_BITS - 1));
  assign good  = last && frame_ok(frame);
  assign pop   = ~nextdata_n & ~empty;
  assign ready = ~empty;

  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .wr_en   (good),
    .wr_data (frame[PAR-1:START+1]),
    .rd_en   (~nextdata_n),
    .rd_data (data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s         <= 3'b111;
      d         <= 2'b11;
      cnt       <= '0;
      sr        <= '0;
      wd        <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s         <= {s[1:0], ps2_clk};
      d         <= {d[0], ps2_data};
      frame_err <= last & ~frame_ok(frame);
      // A pop in the same cycle makes room, so a write into a full FIFO is not an overflow.
      if (pop)               overflow <= 1'b0;
      else if (good && full) overflow <= 1'b1;
      if (fall) begin
        wd  <= '0;
        sr  <= frame[PS2_FRAME_BITS-1:1];
        cnt <= last ? 4'd0 : cnt + 4'd1;
      end else if (cnt != 4'd0) begin
        if (wd == WDW'(TIMEOUT_CYC - 1)) begin
          cnt <= '0;
          wd  <= '0;
        end else begin
          wd <= wd + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - randomized scoreboard bench for ps2_rx
module tb_ps2_rx;
  localparam int DEPTH = 8;
  localparam int TMO   = 2000;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int checks = 0;
  int passes = 0;
  int err_seen = 0;
  int exp_err = 0;
  int mcount = 0;
  bit exp_ovf = 1'b0;
  bit prev_ready = 1'b0;
  byte unsigned exp_q[$];

  ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares the head byte whenever the DUT is about to be popped.
  always @(negedge clk) begin
    if (clrn) begin
      if (frame_err) err_seen++;
      if (ready && !nextdata_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pop_unexpected: got %0h expected none", data);
        end else begin
          chk("pop_data", data, exp_q.pop_front());
        end
      end
      if (prev_ready && !ready) chk("data_zero_on_empty", data, 0);
      prev_ready = ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit pop_at_fall);
    int hp;
    hp = $urandom_range(4, 8);
    ps2_data = b;
    cyc(hp);
    ps2_clk = 1'b0;
    if (pop_at_fall) begin
      // The 11th falling edge is acted on at the third clk edge after the pin drops.
      cyc(2);
      nextdata_n = 1'b0;
      cyc(1);
      nextdata_n = 1'b1;
      cyc(hp - 3);
    end else begin
      cyc(hp);
    end
    ps2_clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send_frame(input byte unsigned b, input int kind, input int nbits, input bit pop_last);
    logic [10:0] f;
    f[0]    = (kind == 3);
    f[8:1]  = b;
    f[9]    = (~^b) ^ (kind == 1);
    f[10]   = (kind != 2);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], pop_last && (i == 10));
    cyc(3);
  endtask

  task automatic model_frame(input byte unsigned b, input int kind);
    if (kind == 0) begin
      if (mcount < DEPTH) begin
        exp_q.push_back(b);
        mcount++;
      end else begin
        exp_ovf = 1'b1;
      end
    end else begin
      exp_err++;
    end
  endtask

  task automatic frame(input byte unsigned b, input int kind);
    send_frame(b, kind, 11, 1'b0);
    model_frame(b, kind);
  endtask

  task automatic check_state(input string name);
    chk({name, "_ready"}, ready, (mcount > 0));
    chk({name, "_overflow"}, overflow, exp_ovf);
    chk({name, "_frame_err_count"}, err_seen, exp_err);
  endtask

  task automatic pop_burst(input int n);
    nextdata_n = 1'b0;
    cyc(n);
    nextdata_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (mcount > 0) begin
        mcount--;
        exp_ovf = 1'b0;
      end
    end
    cyc(1);
  endtask

  task automatic drain();
    while (mcount > 0) pop_burst(1);
  endtask

  initial begin
    int kind;
    cyc(3);
    chk("reset_ready", ready, 0);
    chk("reset_data", data, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_frame_err", frame_err, 0);
    clrn = 1'b1;
    cyc(2);

    frame(8'h1C, 0);
    check_state("single");
    chk("single_data", data, 8'h1C);
    pop_burst(1);
    check_state("single_popped");
    chk("single_popped_data", data, 0);

    frame(8'hF0, 0);
    frame(8'h1C, 0);
    check_state("break");
    drain();
    check_state("break_drained");

    frame(8'h1C, 1);
    check_state("bad_parity");
    frame(8'h1C, 2);
    check_state("bad_stop");
    frame(8'h1C, 3);
    check_state("bad_start");

    for (int i = 1; i <= 9; i++) frame(byte'(i), 0);
    check_state("overflow_set");
    pop_burst(1);
    check_state("overflow_cleared");
    drain();
    check_state("overflow_drained");

    send_frame(8'h00, 0, 5, 1'b0);
    cyc(TMO + 10);
    frame(8'h29, 0);
    check_state("timeout");
    chk("timeout_data", data, 8'h29);
    drain();

    frame(8'h5A, 0);
    send_frame(8'h00, 0, 5, 1'b0);
    clrn = 1'b0;
    exp_q.delete();
    mcount = 0;
    exp_ovf = 1'b0;
    cyc(2);
    chk("midreset_ready", ready, 0);
    chk("midreset_data", data, 0);
    chk("midreset_overflow", overflow, 0);
    chk("midreset_frame_err", frame_err, 0);
    clrn = 1'b1;
    cyc(2);
    frame(8'h33, 0);
    check_state("after_reset");
    chk("after_reset_data", data, 8'h33);
    drain();

    for (int i = 0; i < DEPTH; i++) frame(byte'(8'h40 + i), 0);
    check_state("full");
    send_frame(8'h48, 0, 11, 1'b1);
    mcount--;
    exp_ovf = 1'b0;
    model_frame(8'h48, 0);
    check_state("full_pop");
    chk("full_pop_count", mcount, DEPTH);
    drain();
    check_state("full_pop_drained");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 7) ? 0 : kind - 6;
      frame(byte'($urandom_range(0, 255)), kind);
      check_state("rand_frame");
      kind = $urandom_range(0, 3);
      if (kind > 0) begin
        pop_burst(kind);
        check_state("rand_pop");
      end
    end
    drain();
    check_state("final");
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
